ascon_hash_ctrl: RTL and testbench

//  Ascon-Hash / Ascon-Hasha sponge controller. It is the initiator side of the en_p8/en_p12/done

---
 rtl/ascon_hash_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_ascon_hash_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_hash_ctrl.sv
// Ascon-Hash / Ascon-Hasha sponge controller.
// Owns the 320-bit sponge state, absorbs a 64-bit message stream, drives the
// en_p12/en_p8/done handshake of the multicycle permutation core and squeezes
// the 256-bit digest as four 64-bit beats (h0 first).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start; state regs hold last value
//   S_INIT   | p12 over IV||0
//   S_ABSORB | msg_ready=1, XOR next word into x0
//   S_PERM_A | inter-block permutation (p12 Hash / p8 Hasha)
//   S_FINAL  | p12 after the padded last block
//   S_SQ_OUT | presenting x0 as digest beat cnt
//   S_PERM_S | inter-beat squeeze permutation (p12 Hash / p8 Hasha)
//
// The permutation request is a Moore output of the state, suppressed for one
// cycle after every done so the core always sees en low between requests and
// restarts from round 0, even on back-to-back permutations (PERM_A -> FINAL).

module ascon_hash_ctrl #(
  parameter bit HASHA = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [63:0] msg_data,
  input  logic        msg_last,
  input  logic [3:0]  msg_bytes,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [63:0] dig_data,
  output logic        dig_last,
  output logic        perm_en_p12,
  output logic        perm_en_p8,
  output logic [63:0] perm_x0_o,
  output logic [63:0] perm_x1_o,
  output logic [63:0] perm_x2_o,
  output logic [63:0] perm_x3_o,
  output logic [63:0] perm_x4_o,
  input  logic [63:0] perm_x0_i,
  input  logic [63:0] perm_x1_i,
  input  logic [63:0] perm_x2_i,
  input  logic [63:0] perm_x3_i,
  input  logic [63:0] perm_x4_i,
  input  logic        perm_done
);

  localparam logic [63:0] IV      = HASHA ? 64'h00400c0400000100 : 64'h00400c0000000100;
  localparam logic [63:0] PAD_MSB = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ABSORB,
    S_PERM_A,
    S_FINAL,
    S_SQ_OUT,
    S_PERM_S
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] x0_q, x1_q, x2_q, x3_q, x4_q;
  logic [63:0] x0_d, x1_d, x2_d, x3_d, x4_d;
  logic        pad_pending_q, pad_pending_d;
  logic        gap_q, gap_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        perm_state;
  logic        perm_long;
  logic        perm_req;
  logic        perm_fire;
  logic [3:0]  n_eff;
  logic [6:0]  byte_shift;
  logic [63:0] byte_mask;
  logic [63:0] pad_word;
  logic [63:0] last_word;

  assign perm_x0_o = x0_q;
  assign perm_x1_o = x1_q;
  assign perm_x2_o = x2_q;
  assign perm_x3_o = x3_q;
  assign perm_x4_o = x4_q;

  // Last-word masking and 0x80 padding; n=8 shifts everything out (mask all ones, pad 0).
  always_comb begin
    n_eff      = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    byte_shift = {n_eff, 3'b000};
    byte_mask  = ~({64{1'b1}} >> byte_shift);
    pad_word   = PAD_MSB >> byte_shift;
    last_word  = (msg_data & byte_mask) ^ pad_word;
  end

  // Permutation request decode: which rounds, and whether this cycle completes it.
  always_comb begin
    perm_state = (state_q == S_INIT) || (state_q == S_PERM_A) ||
                 (state_q == S_FINAL) || (state_q == S_PERM_S);
    perm_long  = (state_q == S_INIT) || (state_q == S_FINAL) || !HASHA;
    perm_req   = perm_state && !gap_q;
    perm_fire  = perm_req && perm_done;
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d       = state_q;
    x0_d          = x0_q;
    x1_d          = x1_q;
    x2_d          = x2_q;
    x3_d          = x3_q;
    x4_d          = x4_q;
    pad_pending_d = pad_pending_q;
    cnt_d         = cnt_q;
    gap_d         = 1'b0;
    busy          = (state_q != S_IDLE);
    msg_ready     = 1'b0;
    dig_valid     = 1'b0;
    dig_data      = 64'd0;
    dig_last      = 1'b0;
    perm_en_p12   = perm_req && perm_long;
    perm_en_p8    = perm_req && !perm_long;

    if (perm_fire) begin
      x0_d  = perm_x0_i;
      x1_d  = perm_x1_i;
      x2_d  = perm_x2_i;
      x3_d  = perm_x3_i;
      x4_d  = perm_x4_i;
      gap_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d          = IV;
          x1_d          = 64'd0;
          x2_d          = 64'd0;
          x3_d          = 64'd0;
          x4_d          = 64'd0;
          pad_pending_d = 1'b0;
          cnt_d         = 2'd0;
          state_d       = S_INIT;
        end
      end
      S_INIT: begin
        if (perm_fire) state_d = S_ABSORB;
      end
      S_ABSORB: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          if (!msg_last) begin
            x0_d    = x0_q ^ msg_data;
            state_d = S_PERM_A;
          end else begin
            x0_d = x0_q ^ last_word;
            if (n_eff == 4'd8) begin
              pad_pending_d = 1'b1;
              state_d       = S_PERM_A;
            end else begin
              state_d = S_FINAL;
            end
          end
        end
      end
      S_PERM_A: begin
        if (perm_fire) begin
          if (pad_pending_q) begin
            x0_d          = perm_x0_i ^ PAD_MSB;
            pad_pending_d = 1'b0;
            state_d       = S_FINAL;
          end else begin
            state_d = S_ABSORB;
          end
        end
      end
      S_FINAL: begin
        if (perm_fire) begin
          cnt_d   = 2'd0;
          state_d = S_SQ_OUT;
        end
      end
      S_SQ_OUT: begin
        dig_valid = 1'b1;
        dig_data  = x0_q;
        dig_last  = (cnt_q == 2'd3);
        if (dig_ready) begin
          if (cnt_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = S_PERM_S;
          end
        end
      end
      S_PERM_S: begin
        if (perm_fire) state_d = S_SQ_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and sponge state; async reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      x0_q          <= 64'd0;
      x1_q          <= 64'd0;
      x2_q          <= 64'd0;
      x3_q          <= 64'd0;
      x4_q          <= 64'd0;
      pad_pending_q <= 1'b0;
      gap_q         <= 1'b0;
      cnt_q         <= 2'd0;
    end else begin
      state_q       <= state_d;
      x0_q          <= x0_d;
      x1_q          <= x1_d;
      x2_q          <= x2_d;
      x3_q          <= x3_d;
      x4_q          <= x4_d;
      pad_pending_q <= pad_pending_d;
      gap_q         <= gap_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Bench for ascon_hash_ctrl: one Ascon-Hash and one Ascon-Hasha instance, each
// with a behavioural permutation core of variable latency. Expected digests come
// from a software sponge model (or a KAT) and are queued per beat.

module tb_ascon_hash_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [255:0] KAT_HASH_EMPTY =
    256'h7346bc14f036e87ae03d0997913088f5f68411434b3cf8b54fa796a80d251f91;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int           inst;
    int           len;
    int           gap_pct;
    int           stall_beat;
    bit           use_kat;
    logic [255:0] kat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  logic [7:0] msg_buf [24];

  logic [1:0]  start_v, msg_valid_v, msg_last_v, dig_ready_v;
  logic [63:0] msg_data_v  [2];
  logic [3:0]  msg_bytes_v [2];
  logic [1:0]  busy_v, msg_ready_v, dig_valid_v, dig_last_v, en12_v, en8_v;
  logic [63:0] dig_data_v  [2];
  logic [319:0] px_v       [2];

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_p(input logic [319:0] s, input int rounds);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = 12 - rounds; r < 12; r++) begin
      x2 ^= {56'd0, 4'(15 - r), 4'(r)};
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [255:0] hash_model(input logic [7:0] m [24], input int len, input bit hasha);
    logic [319:0] s;
    logic [63:0]  w;
    logic [255:0] h;
    int pb, nfull;
    pb    = hasha ? 8 : 12;
    s     = {(hasha ? 64'h00400c0400000100 : 64'h00400c0000000100), 256'd0};
    s     = ascon_p(s, 12);
    nfull = len / 8;
    for (int b = 0; b < nfull; b++) begin
      w = '0;
      for (int i = 0; i < 8; i++) w[63 - 8*i -: 8] = m[8*b + i];
      s[319:256] ^= w;
      s = ascon_p(s, pb);
    end
    w = '0;
    for (int i = 0; i < len % 8; i++) w[63 - 8*i -: 8] = m[8*nfull + i];
    w[63 - 8*(len % 8) -: 8] = 8'h80;
    s[319:256] ^= w;
    s = ascon_p(s, 12);
    for (int i = 0; i < 4; i++) begin
      h[255 - 64*i -: 64] = s[319:256];
      if (i < 3) s = ascon_p(s, pb);
    end
    return h;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        busy, msg_ready, dig_valid, dig_last, en12, en8, done;
    logic [63:0] dig_data;
    logic [63:0] xo0, xo1, xo2, xo3, xo4, xi0, xi1, xi2, xi3, xi4;
    int          cnt, extra;
    logic [319:0] res;
    logic        prev_en, prev_done, prev_dv, prev_dr;
    logic [63:0] prev_dd;
    logic [319:0] prev_x;
    exp_t        e;

    ascon_hash_ctrl #(.HASHA(g == 1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_v[g]),
      .busy        (busy),
      .msg_valid   (msg_valid_v[g]),
      .msg_ready   (msg_ready),
      .msg_data    (msg_data_v[g]),
      .msg_last    (msg_last_v[g]),
      .msg_bytes   (msg_bytes_v[g]),
      .dig_valid   (dig_valid),
      .dig_ready   (dig_ready_v[g]),
      .dig_data    (dig_data),
      .dig_last    (dig_last),
      .perm_en_p12 (en12),
      .perm_en_p8  (en8),
      .perm_x0_o   (xo0),
      .perm_x1_o   (xo1),
      .perm_x2_o   (xo2),
      .perm_x3_o   (xo3),
      .perm_x4_o   (xo4),
      .perm_x0_i   (xi0),
      .perm_x1_i   (xi1),
      .perm_x2_i   (xi2),
      .perm_x3_i   (xi3),
      .perm_x4_i   (xi4),
      .perm_done   (done)
    );

    assign busy_v[g]      = busy;
    assign msg_ready_v[g] = msg_ready;
    assign dig_valid_v[g] = dig_valid;
    assign dig_last_v[g]  = dig_last;
    assign en12_v[g]      = en12;
    assign en8_v[g]       = en8;
    assign dig_data_v[g]  = dig_data;
    assign px_v[g]        = {xo0, xo1, xo2, xo3, xo4};

    // Permutation core: nominal p12 done on 4th en cycle, p8 on 3rd, plus 0..2 extra cycles.
    assign {xi0, xi1, xi2, xi3, xi4} = done ? res : {5{64'hBAD0_C0DE_BAD0_C0DE}};
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= 0; extra <= 0; done <= 1'b0; res <= '0;
      end else if (done) begin
        done <= 1'b0; cnt <= 0; extra <= int'($urandom_range(0, 2));
      end else if (en12 || en8) begin
        cnt <= cnt + 1;
        if (cnt + 1 == (en12 ? 4 : 3) + extra - 1) begin
          done <= 1'b1;
          res  <= ascon_p({xo0, xo1, xo2, xo3, xo4}, en12 ? 12 : 8);
        end
      end
    end

    // Bus rules, digest hold and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
      if (rst_n) begin
        if (en12 || en8) check("en_onehot", {en12, en8} == 2'b11, 0);
        if (prev_done) check("en_gap_after_done", en12 | en8, 0);
        else if (prev_en) begin
          check("en_held_until_done", en12 | en8, 1);
          if (en12 | en8) check("perm_x_stable", {xo0, xo1, xo2, xo3, xo4}, prev_x);
        end
        if (!busy) check("idle_outputs", {msg_ready, dig_valid, en12, en8}, 0);
        if (prev_dv && !prev_dr) check("dig_hold", {dig_valid, dig_data}, {1'b1, prev_dd});
        if (dig_valid && dig_ready_v[g]) begin
          check("sb_nonempty", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("dig_data", dig_data, e.data);
            check("dig_last", dig_last, e.last);
          end
        end
      end
      prev_en   <= rst_n && (en12 || en8);
      prev_done <= rst_n && done;
      prev_dv   <= rst_n && dig_valid;
      prev_dr   <= dig_ready_v[g];
      prev_dd   <= dig_data;
      prev_x    <= {xo0, xo1, xo2, xo3, xo4};
    end
  end

  task automatic send_start(input int k);
    @(posedge clk); #1 start_v[k] = 1'b1;
    @(posedge clk); #1 start_v[k] = 1'b0;
    check("busy_after_start", busy_v[k], 1);
  endtask

  task automatic run_vec(input vec_t v);
    int k, nw;
    bit ok;
    logic [255:0] expd;
    logic [63:0]  w;
    exp_t e;
    k = v.inst;
    for (int i = 0; i < 24; i++) msg_buf[i] = 8'(i*37 + v.len*11 + 5);
    expd = v.use_kat ? v.kat : hash_model(msg_buf, v.len, k == 1);
    sb_q.delete();
    for (int i = 0; i < 4; i++) begin
      e.data = expd[255 - 64*i -: 64];
      e.last = (i == 3);
      sb_q.push_back(e);
    end
    send_start(k);
    nw = (v.len == 0) ? 1 : (v.len + 7) / 8;
    for (int wi = 0; wi < nw; wi++) begin
      for (int gc = 0; gc < 8 && $urandom_range(0, 99) < v.gap_pct; gc++) begin
        @(posedge clk); #1;
      end
      for (int b = 0; b < 8; b++) w[63 - 8*b -: 8] = (8*wi + b < v.len) ? msg_buf[8*wi + b] : 8'hA5;
      msg_data_v[k]  = w;
      msg_last_v[k]  = (wi == nw - 1);
      msg_bytes_v[k] = (wi == nw - 1) ? 4'(v.len - 8*wi) : 4'd8;
      msg_valid_v[k] = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (msg_ready_v[k]) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1 msg_valid_v[k] = 1'b0;
      check("msg_accept", ok, 1);
      if (!ok) return;
    end
    for (int b = 0; b < 4; b++) begin
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (dig_valid_v[k]) begin ok = 1'b1; break; end
      end
      check("dig_valid_wait", ok, 1);
      if (!ok) return;
      if (b == v.stall_beat) repeat (20) @(negedge clk);
      @(posedge clk); #1;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      dig_ready_v[k] = 1'b1;
      @(posedge clk); #1 dig_ready_v[k] = 1'b0;
    end
    @(negedge clk);
    check("busy_after_last_beat", busy_v[k], 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic t5_reset_abort();
    bit ok;
    sb_q.delete();
    send_start(0);
    msg_data_v[0]  = 64'h0123_4567_89ab_cdef;
    msg_last_v[0]  = 1'b0;
    msg_bytes_v[0] = 4'd8;
    msg_valid_v[0] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (msg_ready_v[0]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 msg_valid_v[0] = 1'b0;
    check("t5_msg_accept", ok, 1);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (en12_v[0]) begin ok = 1'b1; break; end
    end
    check("t5_perm_a_en", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_ctrl", {busy_v[0], msg_ready_v[0], dig_valid_v[0], dig_last_v[0],
                            en12_v[0], en8_v[0], dig_data_v[0]}, 0);
    check("t5_async_state", px_v[0], 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d tests expected completion", n_tests);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    start_v     = '0;
    msg_valid_v = '0;
    msg_last_v  = '0;
    dig_ready_v = '0;
    for (int k = 0; k < 2; k++) begin
      msg_data_v[k]  = '0;
      msg_bytes_v[k] = '0;
    end

    vecs.push_back('{0, 0, 0, -1, 1'b1, KAT_HASH_EMPTY});
    vecs.push_back('{0, 8, 0, -1, 1'b0, 256'd0});
    for (int l = 1; l <= 7; l++) vecs.push_back('{0, l, 30, -1, 1'b0, 256'd0});
    vecs.push_back('{0, 17, 50, -1, 1'b0, 256'd0});
    vecs.push_back('{0, 16, 0, 1, 1'b0, 256'd0});
    vecs.push_back('{1, 0, 0, -1, 1'b0, 256'd0});
    vecs.push_back('{1, 9, 40, 2, 1'b0, 256'd0});

    #13;
    for (int k = 0; k < 2; k++) begin
      check("reset_ctrl", {busy_v[k], msg_ready_v[k], dig_valid_v[k], dig_last_v[k],
                           en12_v[k], en8_v[k], dig_data_v[k]}, 0);
      check("reset_state", px_v[k], 0);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    t5_reset_abort();
    run_vec(vecs[0]);

    // Start pulses while busy must not restart the hash.
    begin
      vec_t v;
      v = vecs[1];
      fork
        run_vec(v);
        begin
          repeat (12) @(posedge clk);
          #1 start_v[0] = 1'b1;
          repeat (3) @(posedge clk);
          #1 start_v[0] = 1'b0;
        end
      join
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
